score_scan_display: RTL and testbench

- Parametrised N-channel event scoreboard with a multiplexed 7-segment display driver.
- Each channel synchronises an asynchronous event line, detects rising edges, and counts them in a multi-digit BCD counter with overflow.
- The counters are time-multiplexed onto one common-cathode digit bus. The scan is driven by the 1 kHz system tick, and a blank gap digit separates adjacent channel fields.
- Successor to the fixed 3-field try/correct/wrong scoreboard.

---
 rtl/score_scan_display_if.sv | 25 ++
 rtl/score_scan_display.sv | 144 ++++++++++++++
 tb/tb_score_scan_display.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_scan_display_if.sv
// Signal bundle for the event scoreboard: event/clear inputs, counter
// values, overflow flags and the multiplexed 7-segment digit bus.
interface score_scan_display_if #(
  parameter int NUM_CH     = 3,
  parameter int CNT_DIGITS = 2
);
  localparam int ND = NUM_CH*(CNT_DIGITS+1)-1;

  logic [NUM_CH-1:0]              evt;
  logic                           clr;
  logic [NUM_CH*CNT_DIGITS*4-1:0] count_bcd;
  logic [NUM_CH-1:0]              ovf;
  logic [ND-1:0]                  seg_com;
  logic [7:0]                     seg_data;

  modport master (
    output evt, clr,
    input  count_bcd, ovf, seg_com, seg_data
  );

  modport slave (
    input  evt, clr,
    output count_bcd, ovf, seg_com, seg_data
  );
endinterface

// File: rtl/score_scan_display.sv
// N-channel BCD event scoreboard: synchronised edge counting per channel,
// scanned onto one common-cathode digit bus with a blank gap between fields.
module score_scan_display #(
  parameter int NUM_CH      = 3,
  parameter int CNT_DIGITS  = 2,
  parameter bit SATURATE    = 1'b0,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input logic                 clk_1k,
  input logic                 reset,
  score_scan_display_if.slave bus
);
  localparam int ND = NUM_CH*(CNT_DIGITS+1)-1;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ND-1);

  typedef logic [CNT_DIGITS-1:0][3:0] cnt_t;

  logic [NUM_CH-1:0]               r_s1, r_s2, r_s3;
  logic [NUM_CH-1:0]               w_edge;
  cnt_t [NUM_CH-1:0]               r_cnt;
  cnt_t [NUM_CH-1:0]               w_inc;
  logic [NUM_CH-1:0][CNT_DIGITS:0] w_carry;
  logic [NUM_CH-1:0]               w_all9;
  logic [NUM_CH-1:0]               r_ovf;
  logic [NUM_CH-1:0][CNT_DIGITS:0] w_nz;
  logic [NUM_CH-1:0][CNT_DIGITS-1:0] w_blank;
  logic [IW-1:0]                   r_idx;
  logic [ND-1:0]                   r_com, w_com;
  logic [7:0]                      r_data, w_data;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h3F;
      4'd1:    f_decode = 7'h06;
      4'd2:    f_decode = 7'h5B;
      4'd3:    f_decode = 7'h4F;
      4'd4:    f_decode = 7'h66;
      4'd5:    f_decode = 7'h6D;
      4'd6:    f_decode = 7'h7D;
      4'd7:    f_decode = 7'h07;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h6F;
      default: f_decode = 7'h00;
    endcase
  endfunction

  // Two synchroniser flops, then s3 holds the previous level for edge detect.
  always_ff @(posedge clk_1k or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= bus.evt;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  // Decimal ripple: a digit increments only while every lower digit is 9.
  always_comb begin
    w_carry = '0;
    w_inc   = '0;
    w_all9  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_carry[c][0] = 1'b1;
      for (int k = 0; k < CNT_DIGITS; k++) begin
        if (!w_carry[c][k])
          w_inc[c][k] = r_cnt[c][k];
        else if (r_cnt[c][k] == 4'd9)
          w_inc[c][k] = 4'd0;
        else
          w_inc[c][k] = r_cnt[c][k] + 4'd1;
        w_carry[c][k+1] = w_carry[c][k] & (r_cnt[c][k] == 4'd9);
      end
      w_all9[c] = w_carry[c][CNT_DIGITS];
    end
  end

  always_ff @(posedge clk_1k or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (bus.clr) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_edge[c]) begin
          if (w_all9[c])
            r_ovf[c] <= 1'b1;
          if (!(w_all9[c] && SATURATE))
            r_cnt[c] <= w_inc[c];
        end
      end
    end
  end

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    w_nz    = '0;
    w_blank = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = CNT_DIGITS-1; k >= 0; k--) begin
        w_nz[c][k]    = w_nz[c][k+1] | (r_cnt[c][k] != 4'd0);
        w_blank[c][k] = LZ_SUPPRESS && (k > 0) && !w_nz[c][k];
      end
    end
  end

  // Gap positions never match a channel digit and so stay dark.
  always_comb begin
    w_com  = '1;
    w_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < CNT_DIGITS; k++) begin
        if ((r_idx == IW'(c*(CNT_DIGITS+1)+k)) && !w_blank[c][k]) begin
          w_com[c*(CNT_DIGITS+1)+k] = 1'b0;
          w_data = {1'b0, f_decode(r_cnt[c][k])};
        end
      end
    end
  end

  always_ff @(posedge clk_1k or negedge reset) begin
    if (!reset) begin
      r_idx  <= '0;
      r_com  <= '1;
      r_data <= '0;
    end else begin
      r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      r_com  <= w_com;
      r_data <= w_data;
    end
  end

  assign bus.count_bcd = r_cnt;
  assign bus.ovf       = r_ovf;
  assign bus.seg_com   = r_com;
  assign bus.seg_data  = r_data;
endmodule

// File: tb/tb_score_scan_display.sv
// Bench for score_scan_display: a wrapping/zero-suppressing instance and a
// saturating/full-digit instance share the same stimulus.
`timescale 1ns/1ps
module tb_score_scan_display;
  localparam int NUM_CH     = 3;
  localparam int CNT_DIGITS = 2;
  localparam int ND         = NUM_CH*(CNT_DIGITS+1)-1;
  localparam int CBW        = NUM_CH*CNT_DIGITS*4;
  localparam int SW         = 2*(ND+8);
  localparam int CW         = 2*(CBW+NUM_CH);
  localparam int MAXV       = 99;

  logic clk_1k = 1'b0;
  logic reset  = 1'b0;
  logic [NUM_CH-1:0] evt = '0;
  logic clr = 1'b0;

  score_scan_display_if #(.NUM_CH(NUM_CH), .CNT_DIGITS(CNT_DIGITS)) bus_a();
  score_scan_display_if #(.NUM_CH(NUM_CH), .CNT_DIGITS(CNT_DIGITS)) bus_b();

  assign bus_a.evt = evt;
  assign bus_a.clr = clr;
  assign bus_b.evt = evt;
  assign bus_b.clr = clr;

  score_scan_display #(.NUM_CH(NUM_CH), .CNT_DIGITS(CNT_DIGITS),
                       .SATURATE(1'b0), .LZ_SUPPRESS(1'b1)) dut_a (
    .clk_1k (clk_1k),
    .reset  (reset),
    .bus    (bus_a.slave)
  );

  score_scan_display #(.NUM_CH(NUM_CH), .CNT_DIGITS(CNT_DIGITS),
                       .SATURATE(1'b1), .LZ_SUPPRESS(1'b0)) dut_b (
    .clk_1k (clk_1k),
    .reset  (reset),
    .bus    (bus_b.slave)
  );

  always #5 clk_1k = ~clk_1k;

  int n_pass  = 0;
  int n_total = 0;
  logic [SW-1:0] exp_q[$];
  logic [CW-1:0] cnt_q[$];

  int m_cnt_a[NUM_CH];
  int m_cnt_b[NUM_CH];
  bit m_ovf_a[NUM_CH];
  bit m_ovf_b[NUM_CH];
  int m_pos;
  logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Position the next clock edge will display.
  always @(posedge clk_1k or negedge reset) begin
    if (!reset) m_pos <= 0;
    else        m_pos <= (m_pos + 1) % ND;
  end

  function automatic logic [15:0] exp_disp(input int cnt, input bit lz, input int p);
    int k, pw, dig;
    logic [7:0] com;
    k = p % (CNT_DIGITS+1);
    if (k == CNT_DIGITS) return {8'hFF, 8'h00};
    pw = 1;
    for (int j = 0; j < k; j++) pw = pw * 10;
    if (lz && k > 0 && cnt < pw) return {8'hFF, 8'h00};
    dig = (cnt / pw) % 10;
    com = 8'hFF;
    com[p] = 1'b0;
    return {com, 1'b0, seg_tab[dig]};
  endfunction

  function automatic logic [CBW+NUM_CH-1:0] exp_cnt(input bit sel_b);
    logic [CBW-1:0] v;
    logic [NUM_CH-1:0] o;
    int x;
    for (int c = 0; c < NUM_CH; c++) begin
      x    = sel_b ? m_cnt_b[c] : m_cnt_a[c];
      o[c] = sel_b ? m_ovf_b[c] : m_ovf_a[c];
      for (int k = 0; k < CNT_DIGITS; k++) begin
        v[(c*CNT_DIGITS+k)*4 +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return {o, v};
  endfunction

  task automatic model_inc(input int c);
    if (m_cnt_a[c] == MAXV) begin m_cnt_a[c] = 0; m_ovf_a[c] = 1'b1; end
    else m_cnt_a[c]++;
    if (m_cnt_b[c] == MAXV) m_ovf_b[c] = 1'b1;
    else m_cnt_b[c]++;
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt_a[c] = 0; m_cnt_b[c] = 0; m_ovf_a[c] = 1'b0; m_ovf_b[c] = 1'b0;
    end
  endtask

  task automatic expect_counts();
    cnt_q.push_back({exp_cnt(1'b0), exp_cnt(1'b1)});
  endtask

  task automatic check_counts(input string tag);
    logic [CW-1:0] e, got;
    n_total++;
    if (cnt_q.size() == 0) begin
      $display("FAIL %s: no expected count queued", tag);
      return;
    end
    e   = cnt_q.pop_front();
    got = {bus_a.ovf, bus_a.count_bcd, bus_b.ovf, bus_b.count_bcd};
    if (got !== e) $display("FAIL %s: ovf/count got %h expected %h", tag, got, e);
    else n_pass++;
  endtask

  task automatic check_scan(input int n, input string tag);
    logic [SW-1:0] e, got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_1k);
      exp_q.push_back({exp_disp(m_cnt_a[m_pos/(CNT_DIGITS+1)], 1'b1, m_pos),
                       exp_disp(m_cnt_b[m_pos/(CNT_DIGITS+1)], 1'b0, m_pos)});
      @(posedge clk_1k); #1;
      e   = exp_q.pop_front();
      got = {bus_a.seg_com, bus_a.seg_data, bus_b.seg_com, bus_b.seg_data};
      n_total++;
      if (got !== e) $display("FAIL %s scan[%0d]: com/data got %h expected %h", tag, i, got, e);
      else n_pass++;
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk_1k);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk_1k); #2;
    reset = 1'b1;
  endtask

  task automatic pulse(input int c, input int hi, input int lo);
    @(negedge clk_1k);
    evt[c] = 1'b1;
    repeat (hi) @(negedge clk_1k);
    evt[c] = 1'b0;
    repeat (lo) @(posedge clk_1k);
    model_inc(c);
  endtask

  task automatic test_reset();
    model_clear();
    repeat (3) @(posedge clk_1k);
    #1;
    n_total++;
    if ({bus_a.seg_com, bus_a.seg_data, bus_b.seg_com, bus_b.seg_data} !== {8'hFF, 8'h00, 8'hFF, 8'h00})
      $display("FAIL reset_seg: got %h %h expected ff 00", bus_a.seg_com, bus_a.seg_data);
    else n_pass++;
    expect_counts();
    check_counts("reset_counts");
    release_reset();
    check_scan(2*ND, "idle_scan");
  endtask

  task automatic test_single_pulse();
    @(negedge clk_1k);
    evt[1] = 1'b1;
    @(posedge clk_1k);
    @(posedge clk_1k); #1;
    n_total++;
    if (bus_a.count_bcd[15:8] !== 8'h00) $display("FAIL pulse_early: ch1 got %h expected 00", bus_a.count_bcd[15:8]);
    else n_pass++;
    @(negedge clk_1k);
    evt[1] = 1'b0;
    @(posedge clk_1k); #1;
    n_total++;
    if (bus_a.count_bcd[15:8] !== 8'h01) $display("FAIL pulse_latency: ch1 got %h expected 01", bus_a.count_bcd[15:8]);
    else n_pass++;
    model_inc(1);
    expect_counts();
    settle();
    check_counts("pulse_counts");
    check_scan(ND, "pulse_scan");
  endtask

  task automatic test_held_high();
    @(negedge clk_1k);
    evt[0] = 1'b1;
    repeat (20) @(negedge clk_1k);
    evt[0] = 1'b0;
    model_inc(0);
    expect_counts();
    settle();
    check_counts("held_high");
  endtask

  task automatic test_many_pulses();
    repeat (5) pulse(2, 1, 1);
    expect_counts();
    settle();
    check_counts("ch2_five");
    check_scan(ND, "ch2_five_scan");
    repeat (7) pulse(2, 1, 1);
    expect_counts();
    settle();
    check_counts("ch2_twelve");
    check_scan(ND, "ch2_twelve_scan");
  endtask

  task automatic test_overflow();
    @(negedge clk_1k);
    clr = 1'b1;
    @(negedge clk_1k);
    clr = 1'b0;
    model_clear();
    expect_counts();
    settle();
    check_counts("clear");
    repeat (100) pulse(0, 1, 1);
    expect_counts();
    settle();
    check_counts("overflow_ch0");
    check_scan(ND, "overflow_scan");
  endtask

  task automatic test_clr_edge();
    repeat (7) pulse(1, 1, 1);
    expect_counts();
    settle();
    check_counts("ch1_seven");
    @(negedge clk_1k);
    evt[1] = 1'b1;
    @(negedge clk_1k);
    @(negedge clk_1k);
    clr = 1'b1;
    model_clear();
    expect_counts();
    @(posedge clk_1k); #1;
    check_counts("clr_vs_edge");
    @(negedge clk_1k);
    clr = 1'b0;
    evt[1] = 1'b0;
    expect_counts();
    @(posedge clk_1k); #1;
    check_counts("clr_no_late_inc");
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < NUM_CH; c++) begin
      int n;
      n = $urandom_range(1, 4);
      repeat (n) pulse(c, 1, 1);
    end
    expect_counts();
    settle();
    check_counts("random_pulses");
    @(negedge clk_1k);
    evt = '1;
    expect_counts();
    @(posedge clk_1k);
    @(posedge clk_1k); #1;
    check_counts("simul_before");
    @(negedge clk_1k);
    evt = '0;
    for (int c = 0; c < NUM_CH; c++) model_inc(c);
    expect_counts();
    @(posedge clk_1k); #1;
    check_counts("simul_same_cycle");
    check_scan(ND, "simul_scan");
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2*ND && !found; i++) begin
      @(posedge clk_1k); #1;
      if (m_pos == 5) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL mid_scan_pos4: position 4 not reached within %0d edges", 2*ND);
    else if ({bus_b.seg_com, bus_b.seg_data} !== exp_disp(m_cnt_b[1], 1'b0, 4))
      $display("FAIL mid_scan_pos4: got %h expected %h", {bus_b.seg_com, bus_b.seg_data}, exp_disp(m_cnt_b[1], 1'b0, 4));
    else n_pass++;
    #1;
    reset = 1'b0;
    #1;
    n_total++;
    if ({bus_a.seg_com, bus_a.seg_data, bus_b.seg_com, bus_b.seg_data} !== {8'hFF, 8'h00, 8'hFF, 8'h00})
      $display("FAIL mid_reset_seg: got %h %h expected ff 00", bus_a.seg_com, bus_a.seg_data);
    else n_pass++;
    model_clear();
    expect_counts();
    check_counts("mid_reset_counts");
    release_reset();
    check_scan(ND+2, "restart_scan");
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_held_high();
    test_many_pulses();
    test_overflow();
    test_clr_edge();
    test_back_to_back();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
